// File: rtl/flag_ctrl_pkg.sv
// Shared definitions for the flag controller.
// Holds the op_code and cond_sel encodings, the flag-set width and the FSM state type.
package flag_ctrl_pkg;

    localparam int unsigned FlagW = 3;  // {c, z, b}

    localparam logic [2:0] OpNop      = 3'd0;
    localparam logic [2:0] OpArith    = 3'd1;
    localparam logic [2:0] OpLogic    = 3'd2;
    localparam logic [2:0] OpClrf     = 3'd3;
    localparam logic [2:0] OpPushf    = 3'd4;
    localparam logic [2:0] OpPopf     = 3'd5;
    localparam logic [2:0] OpIrqEnter = 3'd6;
    localparam logic [2:0] OpReti     = 3'd7;

    localparam logic [2:0] CondAlways = 3'd0;
    localparam logic [2:0] CondC      = 3'd1;
    localparam logic [2:0] CondNc     = 3'd2;
    localparam logic [2:0] CondZ      = 3'd3;
    localparam logic [2:0] CondNz     = 3'd4;
    localparam logic [2:0] CondB      = 3'd5;
    localparam logic [2:0] CondNb     = 3'd6;
    localparam logic [2:0] CondNever  = 3'd7;

    typedef enum logic [0:0] {RUN, IRQ_CLR} state_e;

endpackage

// File: rtl/flag_stack.sv
// DEPTH x 3-bit LIFO of saved flag sets.
// Ports: clk, rst_n (async, active low); push/pop requests (ignored when full/empty);
// din flag set to store; full, empty, sp occupancy (0..DEPTH), top = entry sp-1.
module flag_stack
    import flag_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned SpW   = $clog2(DEPTH) + 1,
    localparam int unsigned AddrW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [FlagW-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [SpW-1:0]   sp,
    output logic [FlagW-1:0] top
);

    logic [FlagW-1:0] mem_q [DEPTH];
    logic [SpW-1:0]   sp_q;
    logic [AddrW-1:0] top_idx;

    assign full    = (sp_q == SpW'(DEPTH));
    assign empty   = (sp_q == '0);
    assign sp      = sp_q;
    // Low bits wrap DEPTH to 0, so subtracting one lands on DEPTH-1 when full.
    assign top_idx = sp_q[AddrW-1:0] - AddrW'(1);
    assign top     = mem_q[top_idx];

    // Contents carry no reset; only sp defines which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[sp_q[AddrW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + SpW'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - SpW'(1);
        end
    end

endmodule

// File: rtl/flag_ctrl.sv
// Flag controller: decodes flag ops into update/clear/hold controls for the flag register,
// keeps a LIFO of saved flag sets and evaluates branch conditions.
// Ports: clk, rst_n (async, active low); op_valid/op_code from decoder; alu_c/z/b results;
// flag_c/z/b current register outputs; cond_sel branch selector.
// Outputs: flag_cb_valid (C/B load), flag_rst (C/B clear), flag_c/z/b_in next values,
// cond_true, busy (decoder stall), sp occupancy, stk_ovf/stk_unf sticky errors.
module flag_ctrl
    import flag_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned SpW = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           op_valid,
    input  logic [2:0]     op_code,
    input  logic           alu_c,
    input  logic           alu_z,
    input  logic           alu_b,
    input  logic           flag_c,
    input  logic           flag_z,
    input  logic           flag_b,
    input  logic [2:0]     cond_sel,
    output logic           flag_cb_valid,
    output logic           flag_rst,
    output logic           flag_c_in,
    output logic           flag_z_in,
    output logic           flag_b_in,
    output logic           cond_true,
    output logic           busy,
    output logic [SpW-1:0] sp,
    output logic           stk_ovf,
    output logic           stk_unf
);

    state_e           state_q;
    logic             busy_q;
    logic             ovf_q, unf_q;
    logic [2:0]       op_eff;
    logic             push, pop, full, empty;
    logic             set_ovf, set_unf, clr_sticky;
    logic [FlagW-1:0] top;

    flag_stack #(
        .DEPTH(DEPTH)
    ) u_stack (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .din  ({flag_c, flag_z, flag_b}),
        .full (full),
        .empty(empty),
        .sp   (sp),
        .top  (top)
    );

    // Ops arriving while the IRQ clear cycle is in progress are dropped.
    assign op_eff = (op_valid && !busy_q) ? op_code : OpNop;

    always_comb begin
        flag_c_in     = flag_c;
        flag_z_in     = flag_z;
        flag_b_in     = flag_b;
        flag_cb_valid = 1'b0;
        flag_rst      = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        set_ovf       = 1'b0;
        set_unf       = 1'b0;
        clr_sticky    = 1'b0;
        if (state_q == IRQ_CLR) begin
            flag_rst  = 1'b1;
            flag_z_in = 1'b0;
        end else begin
            case (op_eff)
                OpArith: begin
                    {flag_c_in, flag_z_in, flag_b_in} = {alu_c, alu_z, alu_b};
                    flag_cb_valid = 1'b1;
                end
                OpLogic: flag_z_in = alu_z;
                OpClrf: begin
                    flag_rst   = 1'b1;
                    flag_z_in  = 1'b0;
                    clr_sticky = 1'b1;
                end
                OpPushf, OpIrqEnter: begin
                    push    = 1'b1;
                    set_ovf = full;
                end
                OpPopf, OpReti: begin
                    if (empty) begin
                        set_unf = 1'b1;
                    end else begin
                        pop = 1'b1;
                        {flag_c_in, flag_z_in, flag_b_in} = top;
                        flag_cb_valid = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (op_eff == OpIrqEnter) begin
                        state_q <= IRQ_CLR;
                        busy_q  <= 1'b1;
                    end
                end
                IRQ_CLR: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
            endcase
            if (clr_sticky) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                if (set_ovf) ovf_q <= 1'b1;
                if (set_unf) unf_q <= 1'b1;
            end
        end
    end

    assign busy    = busy_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;

    always_comb begin
        cond_true = 1'b0;
        unique case (cond_sel)
            CondAlways: cond_true = 1'b1;
            CondC:      cond_true = flag_c;
            CondNc:     cond_true = !flag_c;
            CondZ:      cond_true = flag_z;
            CondNz:     cond_true = !flag_z;
            CondB:      cond_true = flag_b;
            CondNb:     cond_true = !flag_b;
            CondNever:  cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed bench for flag_ctrl with a behavioural flag register closing the loop:
// C/B load or clear on the rising edge, Z samples flag_z_in on the falling edge.
module tb_flag_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic [2:0] op_code;
    logic       alu_c, alu_z, alu_b;
    logic       rc, rz, rb;
    logic [2:0] cond_sel;
    logic       flag_cb_valid, flag_rst, flag_c_in, flag_z_in, flag_b_in;
    logic       cond_true, busy, stk_ovf, stk_unf;
    logic [2:0] sp;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    flag_ctrl #(
        .DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_valid     (op_valid),
        .op_code      (op_code),
        .alu_c        (alu_c),
        .alu_z        (alu_z),
        .alu_b        (alu_b),
        .flag_c       (rc),
        .flag_z       (rz),
        .flag_b       (rb),
        .cond_sel     (cond_sel),
        .flag_cb_valid(flag_cb_valid),
        .flag_rst     (flag_rst),
        .flag_c_in    (flag_c_in),
        .flag_z_in    (flag_z_in),
        .flag_b_in    (flag_b_in),
        .cond_true    (cond_true),
        .busy         (busy),
        .sp           (sp),
        .stk_ovf      (stk_ovf),
        .stk_unf      (stk_unf)
    );

    // Flag register model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc <= 1'b0;
            rb <= 1'b0;
        end else if (flag_rst) begin
            rc <= 1'b0;
            rb <= 1'b0;
        end else if (flag_cb_valid) begin
            rc <= flag_c_in;
            rb <= flag_b_in;
        end
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) rz <= 1'b0;
        else        rz <= flag_z_in;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] alu);
        op_valid = v;
        op_code  = op;
        {alu_c, alu_z, alu_b} = alu;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic exp_ct;

    initial begin
        rst_n    = 1'b0;
        cond_sel = 3'd0;
        drive(1'b0, 3'd0, 3'b000);
        #12;
        chk("rst_sp", 8'(sp), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_sticky", 8'({stk_ovf, stk_unf}), 8'd0);
        chk("rst_ctl", 8'({flag_cb_valid, flag_rst}), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ARITH then LOGIC
        drive(1'b1, 3'd1, 3'b101);
        chk("arith_ctl", 8'({flag_cb_valid, flag_c_in, flag_z_in, flag_b_in}), 8'b1101);
        step();
        chk("arith_flags", 8'({rc, rz, rb}), 8'b101);
        drive(1'b1, 3'd2, 3'b010);
        chk("logic_ctl", 8'({flag_cb_valid, flag_z_in}), 8'b01);
        step();
        chk("logic_flags", 8'({rc, rz, rb}), 8'b111);

        // PUSHF / CLRF / POPF
        drive(1'b1, 3'd1, 3'b101);
        step();
        drive(1'b1, 3'd4, 3'b000);
        step();
        chk("push_sp", 8'(sp), 8'd1);
        drive(1'b1, 3'd3, 3'b000);
        chk("clrf_rst", 8'({flag_rst, flag_z_in}), 8'b10);
        step();
        chk("clrf_flags", 8'({rc, rz, rb}), 8'b000);
        chk("clrf_sp", 8'(sp), 8'd1);
        drive(1'b1, 3'd5, 3'b000);
        chk("popf_ctl", 8'({flag_cb_valid, flag_c_in, flag_z_in, flag_b_in}), 8'b1101);
        step();
        chk("popf_flags", 8'({rc, rz, rb}), 8'b101);
        chk("popf_sp", 8'(sp), 8'd0);

        // Fill with distinct sets: 101, 011, 110, 000, then overflow
        drive(1'b1, 3'd4, 3'b000); step();
        drive(1'b1, 3'd1, 3'b011); step();
        drive(1'b1, 3'd4, 3'b000); step();
        drive(1'b1, 3'd1, 3'b110); step();
        drive(1'b1, 3'd4, 3'b000); step();
        drive(1'b1, 3'd1, 3'b000); step();
        drive(1'b1, 3'd4, 3'b000); step();
        chk("fill_sp", 8'(sp), 8'd4);
        chk("fill_ovf", 8'(stk_ovf), 8'd0);
        drive(1'b1, 3'd4, 3'b000); step();
        chk("ovf_sp", 8'(sp), 8'd4);
        chk("ovf_set", 8'(stk_ovf), 8'd1);
        drive(1'b1, 3'd1, 3'b111); step();
        drive(1'b1, 3'd5, 3'b000); step();
        chk("pop1", 8'({rc, rz, rb}), 8'b000);
        drive(1'b1, 3'd5, 3'b000); step();
        chk("pop2", 8'({rc, rz, rb}), 8'b110);
        drive(1'b1, 3'd5, 3'b000); step();
        chk("pop3", 8'({rc, rz, rb}), 8'b011);
        drive(1'b1, 3'd5, 3'b000); step();
        chk("pop4", 8'({rc, rz, rb}), 8'b101);
        chk("pop4_unf", 8'(stk_unf), 8'd0);
        drive(1'b1, 3'd5, 3'b000);
        chk("unf_ctl", 8'(flag_cb_valid), 8'd0);
        step();
        chk("unf_flags", 8'({rc, rz, rb}), 8'b101);
        chk("unf_sp", 8'(sp), 8'd0);
        chk("unf_sticky", 8'({stk_ovf, stk_unf}), 8'b11);
        drive(1'b1, 3'd3, 3'b000); step();
        chk("clrf_sticky", 8'({stk_ovf, stk_unf}), 8'b00);

        // IRQ_ENTER with flags 011, ARITH while busy ignored, then RETI
        drive(1'b1, 3'd1, 3'b011); step();
        drive(1'b1, 3'd6, 3'b000); step();
        chk("irq_busy", 8'(busy), 8'd1);
        chk("irq_sp", 8'(sp), 8'd1);
        drive(1'b1, 3'd1, 3'b111);
        chk("irq_ctl", 8'({flag_rst, flag_cb_valid, flag_z_in}), 8'b100);
        step();
        chk("irq_done", 8'(busy), 8'd0);
        chk("irq_flags", 8'({rc, rz, rb}), 8'b000);
        drive(1'b1, 3'd7, 3'b000); step();
        chk("reti_flags", 8'({rc, rz, rb}), 8'b011);
        chk("reti_sp", 8'(sp), 8'd0);

        // cond_sel sweep over all flag combinations
        for (int f = 0; f < 8; f++) begin
            drive(1'b1, 3'd1, 3'(f)); step();
            drive(1'b0, 3'd0, 3'b000);
            for (int s = 0; s < 8; s++) begin
                cond_sel = 3'(s);
                #1;
                case (s)
                    0: exp_ct = 1'b1;
                    1: exp_ct = f[2];
                    2: exp_ct = !f[2];
                    3: exp_ct = f[1];
                    4: exp_ct = !f[1];
                    5: exp_ct = f[0];
                    6: exp_ct = !f[0];
                    default: exp_ct = 1'b0;
                endcase
                chk($sformatf("cond_f%0d_s%0d", f, s), 8'(cond_true), 8'(exp_ct));
            end
        end
        cond_sel = 3'd0;

        // Async reset during IRQ_CLR
        drive(1'b1, 3'd5, 3'b000); step();
        chk("pre_unf", 8'(stk_unf), 8'd1);
        drive(1'b1, 3'd6, 3'b000); step();
        chk("pre_busy", 8'(busy), 8'd1);
        drive(1'b0, 3'd0, 3'b000);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 8'(busy), 8'd0);
        chk("arst_sp", 8'(sp), 8'd0);
        chk("arst_sticky", 8'({stk_ovf, stk_unf}), 8'd0);
        chk("arst_rst", 8'(flag_rst), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_busy", 8'(busy), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
